// File: rtl/lcd_status_writer.sv
// lcd_status_writer: renders coffee controller status on an HD44780 16x2 LCD
// over an 8-bit write-only bus. Runs power-on init, then redraws both lines
// whenever the live status differs from the last rendered snapshot.
// Optional: `define LCD_ERROR_TEXT_EN adds err to the snapshot and shows
// "ERROR: CHECK" on line 2 while it is set.
module lcd_status_writer #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SPEEDUP_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cur_flavor,
    input  logic [2:0] cur_type,
    input  logic [1:0] cur_size,
    input  logic [1:0] sys_state,
    input  logic       err,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DATA,
    output logic       ready,
    output logic       frame_done
);
    localparam int unsigned TicksRaw = CLK_HZ / (1_000_000 * SPEEDUP_DIV);
    localparam logic [31:0] US_TICKS = (TicksRaw == 0) ? 32'd1 : 32'(TicksRaw);
    localparam logic [31:0] PwrLimit = 32'd15000 * US_TICKS - 32'd1;
    localparam logic [31:0] UsLimit  = US_TICKS - 32'd1;
    localparam logic [5:0]  InitLast  = 6'd6;
    localparam logic [5:0]  FrameLast = 6'd33;

    typedef enum logic [2:0] {StPwrWait, StInit, StFrame, StDone, StIdle} state_e;
    typedef enum logic [1:0] {PhSetup, PhPulse, PhWait} phase_e;

`ifdef LCD_ERROR_TEXT_EN
    localparam int unsigned SnapW = 9;
    logic [SnapW-1:0] live;
    logic             snap_err;
    assign live     = {err, cur_flavor, cur_type, cur_size, sys_state};
`else
    localparam int unsigned SnapW = 8;
    logic [SnapW-1:0] live;
    logic             snap_err;
    logic             unused_err;
    assign live       = {cur_flavor, cur_type, cur_size, sys_state};
    assign unused_err = err;
`endif

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [5:0]       idx_q, idx_d, idx_nxt;
    logic [SnapW-1:0] snap_q, snap_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, ready_d;
    logic [31:0]      delay_us, wait_limit;

`ifdef LCD_ERROR_TEXT_EN
    assign snap_err = snap_q[8];
`else
    assign snap_err = 1'b0;
`endif

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd4:    b = 8'h0C;
            3'd5:    b = 8'h01;
            3'd6:    b = 8'h06;
            default: b = 8'h38;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] init_delay(input logic [2:0] i);
        logic [31:0] d;
        case (i)
            3'd0:    d = 32'd4100;
            3'd1:    d = 32'd100;
            3'd5:    d = 32'd1640;
            default: d = 32'd40;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] line1_char(input logic flav, input logic [2:0] typ,
                                              input logic [1:0] size, input logic [3:0] pos);
        logic [127:0] line;
        logic [7:0]   digit;
        logic [7:0]   sz;
        logic [3:0]   pos_inv;
        digit = (typ <= 3'd4) ? (8'h31 + {5'd0, typ}) : "?";
        case (size)
            2'd0:    sz = "S";
            2'd1:    sz = "M";
            2'd2:    sz = "L";
            default: sz = "?";
        endcase
        line    = {(flav ? "Coffee2 " : "Coffee1 "), "Type ", digit, " ", sz};
        pos_inv = 4'd15 - pos;
        return line[{pos_inv, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] line2_char(input logic [1:0] sys, input logic e,
                                              input logic [3:0] pos);
        logic [127:0] line;
        logic [3:0]   pos_inv;
        case (sys)
            2'd0:    line = "SELECT          ";
            2'd1:    line = "HEATING WATER   ";
            2'd2:    line = "BREWING         ";
            default: line = "?               ";
        endcase
        if (e) line = "ERROR: CHECK    ";
        pos_inv = 4'd15 - pos;
        return line[{pos_inv, 3'b000} +: 8];
    endfunction

    // Frame layout: 0x80, 16 line-1 chars, 0xC0, 16 line-2 chars; returns {rs, byte}.
    function automatic logic [8:0] frame_byte(input logic [5:0] i, input logic [SnapW-1:0] s,
                                              input logic e);
        logic [8:0] r;
        if (i == 6'd0) begin
            r = 9'h080;
        end else if (i <= 6'd16) begin
            r = {1'b1, line1_char(s[7], s[6:4], s[3:2], 4'(i - 6'd1))};
        end else if (i == 6'd17) begin
            r = 9'h0C0;
        end else begin
            r = {1'b1, line2_char(s[1:0], e, 4'(i - 6'd18))};
        end
        return r;
    endfunction

    assign idx_nxt    = idx_q + 6'd1;
    assign delay_us   = (state_q == StInit) ? init_delay(idx_q[2:0]) : 32'd40;
    assign wait_limit = delay_us * US_TICKS - 32'd1;

    // Next-state: power wait, per-byte SETUP/PULSE/WAIT sequencing, idle change detection.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q + 32'd1;
        idx_d   = idx_q;
        snap_d  = snap_q;
        rs_d    = rs_q;
        data_d  = data_q;
        ready_d = ready_q;
        unique case (state_q)
            StPwrWait: begin
                if (cnt_q == PwrLimit) begin
                    cnt_d   = 32'd0;
                    state_d = StInit;
                    phase_d = PhSetup;
                    idx_d   = 6'd0;
                    rs_d    = 1'b0;
                    data_d  = init_byte(3'd0);
                end
            end
            StInit, StFrame: begin
                unique case (phase_q)
                    PhSetup: if (cnt_q == UsLimit) begin
                        cnt_d   = 32'd0;
                        phase_d = PhPulse;
                    end
                    PhPulse: if (cnt_q == UsLimit) begin
                        cnt_d   = 32'd0;
                        phase_d = PhWait;
                    end
                    default: if (cnt_q == wait_limit) begin
                        cnt_d   = 32'd0;
                        phase_d = PhSetup;
                        if (state_q == StInit && idx_q == InitLast) begin
                            ready_d = 1'b1;
                            state_d = StFrame;
                            idx_d   = 6'd0;
                            snap_d  = live;
                            {rs_d, data_d} = 9'h080;
                        end else if (state_q == StInit) begin
                            idx_d  = idx_nxt;
                            rs_d   = 1'b0;
                            data_d = init_byte(idx_nxt[2:0]);
                        end else if (idx_q == FrameLast) begin
                            state_d = StDone;
                        end else begin
                            idx_d = idx_nxt;
                            {rs_d, data_d} = frame_byte(idx_nxt, snap_q, snap_err);
                        end
                    end
                endcase
            end
            StDone: begin
                cnt_d   = 32'd0;
                state_d = StIdle;
            end
            StIdle: begin
                cnt_d = 32'd0;
                if (live != snap_q) begin
                    state_d = StFrame;
                    phase_d = PhSetup;
                    idx_d   = 6'd0;
                    snap_d  = live;
                    {rs_d, data_d} = 9'h080;
                end
            end
            default: begin
                cnt_d   = 32'd0;
                state_d = StPwrWait;
            end
        endcase
    end

    // State, counters, snapshot and held bus byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StPwrWait;
            phase_q <= PhSetup;
            cnt_q   <= 32'd0;
            idx_q   <= 6'd0;
            snap_q  <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_DATA   = data_q;
    assign LCD_E      = (state_q == StInit || state_q == StFrame) && (phase_q == PhPulse);
    assign ready      = ready_q;
    assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_lcd_status_writer.sv
// Bench for lcd_status_writer at 1 MHz (one cycle per microsecond). Expected
// strobed bytes are queued as stimulus is driven and checked by a negedge monitor.
module tb_lcd_status_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cur_flavor = 1'b0;
    logic [2:0] cur_type = 3'd0;
    logic [1:0] cur_size = 2'd0;
    logic [1:0] sys_state = 2'd0;
    logic       err = 1'b0;
    logic       LCD_RS, LCD_RW, LCD_E, ready, frame_done;
    logic [7:0] LCD_DATA;

    always #5 clk = ~clk;

    lcd_status_writer #(.CLK_HZ(1_000_000), .SPEEDUP_DIV(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cur_flavor (cur_flavor),
        .cur_type   (cur_type),
        .cur_size   (cur_size),
        .sys_state  (sys_state),
        .err        (err),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_E      (LCD_E),
        .LCD_DATA   (LCD_DATA),
        .ready      (ready),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic        rs;
        logic [7:0]  data;
        logic [15:0] gap;  // cycles since previous strobe (or reset release); 0 = unchecked
        logic        rdy;
    } exp_t;

    typedef struct {
        logic         flav;
        logic [2:0]   typ;
        logic [1:0]   size;
        logic [1:0]   sys;
        logic [127:0] l1;
        logic [127:0] l2;
    } vec_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   ncyc = 0, last_strobe = 0, strobes = 0, fd_count = 0, e_len = 0, fd_len = 0;
    logic ready_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: strobe bytes, strobe spacing, pulse widths, ready and frame_done timing.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (rst) last_strobe = ncyc;
        if (LCD_E) begin
            if (e_len == 0) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected strobe: got rs=%0b data=%02h, required none",
                             LCD_RS, LCD_DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe rs/data", {23'd0, LCD_RS, LCD_DATA}, {23'd0, e.rs, e.data});
                    check("ready at strobe", {31'd0, ready}, {31'd0, e.rdy});
                    check("rw", {31'd0, LCD_RW}, 32'd0);
                    if (e.gap != 0) check("strobe gap", ncyc - last_strobe, {16'd0, e.gap});
                end
                last_strobe = ncyc;
            end
            e_len++;
        end else begin
            if (e_len != 0) check("E width", e_len, 1);
            e_len = 0;
        end
        if (frame_done) begin
            if (fd_len == 0) begin
                fd_count++;
                check("frame_done delay", ncyc - last_strobe, 41);
            end
            fd_len++;
        end else begin
            if (fd_len != 0) check("frame_done width", fd_len, 1);
            fd_len = 0;
        end
        if (ready && !ready_prev) check("ready delay", ncyc - last_strobe, 41);
        ready_prev = ready;
    end

    task automatic push1(input logic rs, input logic [7:0] d, input int gap, input logic rdy);
        exp_t e;
        e.rs   = rs;
        e.data = d;
        e.gap  = 16'(gap);
        e.rdy  = rdy;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push1(1'b0, 8'h38, 15001, 1'b0);
        push1(1'b0, 8'h38, 4102, 1'b0);
        push1(1'b0, 8'h38, 102, 1'b0);
        push1(1'b0, 8'h38, 42, 1'b0);
        push1(1'b0, 8'h0C, 42, 1'b0);
        push1(1'b0, 8'h01, 42, 1'b0);
        push1(1'b0, 8'h06, 1642, 1'b0);
    endtask

    task automatic push_frame(input logic [127:0] l1, input logic [127:0] l2, input int g0);
        logic [127:0] t;
        push1(1'b0, 8'h80, g0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            t = l1 << (8 * i);
            push1(1'b1, t[127:120], 42, 1'b1);
        end
        push1(1'b0, 8'hC0, 42, 1'b1);
        for (int i = 0; i < 16; i++) begin
            t = l2 << (8 * i);
            push1(1'b1, t[127:120], 42, 1'b1);
        end
    endtask

    task automatic wait_fd(input int target, input int budget);
        int n = 0;
        while (fd_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("frame_done count", fd_count, target);
        repeat (3) @(posedge clk);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        #1;
        cur_flavor = v.flav;
        cur_type   = v.typ;
        cur_size   = v.size;
        sys_state  = v.sys;
    endtask

    initial begin
        vec_t vecs[6];
        vec_t va, vb, vc;
        int   s0, fd0, n, k;
        vecs[0] = '{1'b0, 3'd0, 2'd0, 2'd0, "Coffee1 Type 1 S", "SELECT          "};
        vecs[1] = '{1'b0, 3'd6, 2'd2, 2'd2, "Coffee1 Type ? L", "BREWING         "};
        vecs[2] = '{1'b1, 3'd4, 2'd1, 2'd1, "Coffee2 Type 5 M", "HEATING WATER   "};
        vecs[3] = '{1'b0, 3'd2, 2'd3, 2'd3, "Coffee1 Type 3 ?", "?               "};
        vecs[4] = '{1'b1, 3'd0, 2'd0, 2'd0, "Coffee2 Type 1 S", "SELECT          "};
        vecs[5] = '{1'b1, 3'd7, 2'd2, 2'd2, "Coffee2 Type ? L", "BREWING         "};
        va      = '{1'b0, 3'd1, 2'd1, 2'd0, "Coffee1 Type 2 M", "SELECT          "};
        vb      = '{1'b1, 3'd1, 2'd1, 2'd0, "Coffee2 Type 2 M", "SELECT          "};
        vc      = '{1'b0, 3'd3, 2'd2, 2'd1, "Coffee1 Type 4 L", "HEATING WATER   "};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset E", {31'd0, LCD_E}, 32'd0);
        check("reset RS", {31'd0, LCD_RS}, 32'd0);
        check("reset DATA", {24'd0, LCD_DATA}, 32'd0);
        check("reset ready", {31'd0, ready}, 32'd0);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);

        // Power-up: init sequence then first frame from all-zero inputs
        push_init();
        push_frame(vecs[0].l1, vecs[0].l2, 42);
        @(negedge clk);
        #1 rst = 1'b0;
        wait_fd(1, 25000);
        check("ready after init", {31'd0, ready}, 32'd1);

        // Static inputs: no further strobes
        s0 = strobes;
        repeat (3000) @(posedge clk);
        check("static no strobes", strobes, s0);

        // Table of input patterns, each rendered by one frame from IDLE
        for (int i = 1; i < 6; i++) begin
            fd0 = fd_count;
            apply(vecs[i]);
            push_frame(vecs[i].l1, vecs[i].l2, 0);
            wait_fd(fd0 + 1, 3000);
        end

        // Flavor change at write index 10: current frame unaffected, then a second frame
        fd0 = fd_count;
        s0  = strobes;
        apply(va);
        push_frame(va.l1, va.l2, 0);
        n = 0;
        while (strobes < s0 + 11 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1 cur_flavor = 1'b1;
        push_frame(vb.l1, vb.l2, 0);
        wait_fd(fd0 + 2, 5000);

        // err handling
`ifdef LCD_ERROR_TEXT_EN
        fd0 = fd_count;
        @(negedge clk);
        #1 err = 1'b1;
        push_frame(vb.l1, "ERROR: CHECK    ", 0);
        wait_fd(fd0 + 1, 3000);
        @(negedge clk);
        #1 err = 1'b0;
        push_frame(vb.l1, vb.l2, 0);
        wait_fd(fd0 + 2, 3000);
`else
        s0 = strobes;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 err = ~err;
            repeat (200) @(posedge clk);
        end
        check("err ignored", strobes, s0);
`endif

        // Reset during the PULSE of frame write 20
        fd0 = fd_count;
        apply(vc);
        push_frame(vc.l1, vc.l2, 0);
        k = 0;
        n = 0;
        while (k < 21 && n < 3000) begin
            @(posedge clk);
            #1;
            if (LCD_E) k++;
            n++;
        end
        check("reached write 20", k, 21);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort E", {31'd0, LCD_E}, 32'd0);
        check("abort DATA", {24'd0, LCD_DATA}, 32'd0);
        check("abort RS", {31'd0, LCD_RS}, 32'd0);
        check("abort ready", {31'd0, ready}, 32'd0);
        exp_q.delete();
        repeat (4) @(posedge clk);
        push_init();
        push_frame(vc.l1, vc.l2, 42);
        @(negedge clk);
        #1 rst = 1'b0;
        wait_fd(fd0 + 1, 25000);

        check("queue drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
